// File: rtl/traffic_pkg.sv
// Shared types and parameter defaults for the traffic phase scheduler.
package traffic_pkg;

    // Scheduler states; the encoding is visible on the phase output
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_NS_GREEN = 3'd1,
        ST_NS_CLEAR = 3'd2,
        ST_EW_GREEN = 3'd3,
        ST_EW_CLEAR = 3'd4
    } state_e;

    // Phase groups: north/south and east/west
    typedef enum logic {
        GRP_NS = 1'b0,
        GRP_EW = 1'b1
    } group_e;

    localparam int MIN_GREEN_DEF = 4;
    localparam int MAX_GREEN_DEF = 16;
    localparam int CLEAR_DEF     = 2;

    localparam int unsigned PHASE_W = 3;

    // Timer width: enough to reach MAX_GREEN-1 plus one bit of headroom
    function automatic int unsigned timer_width(input int max_green);
        return int'($clog2(max_green)) + 1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Restartable saturating phase timer with threshold compares.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = MIN_GREEN_DEF,
    parameter int MAX_GREEN = MAX_GREEN_DEF,
    parameter int CLEAR     = CLEAR_DEF
) (
    input  logic clk,
    input  logic clear,
    output logic min_done,
    output logic max_done,
    output logic clear_done
);

    localparam int unsigned TW = timer_width(MAX_GREEN);

    logic [TW-1:0] count;

    // Count up from zero after each clear; hold at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + TW'(1);
        end
    end

    // Threshold compares against the per-phase limits
    always_comb begin
        min_done   = (count >= TW'(MIN_GREEN - 1));
        max_done   = (count >= TW'(MAX_GREEN - 1));
        clear_done = (count >= TW'(CLEAR - 1));
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-phase (NS/EW) traffic scheduler with request latches, min/max green and all-red clearance.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = MIN_GREEN_DEF,
    parameter int MAX_GREEN = MAX_GREEN_DEF,
    parameter int CLEAR     = CLEAR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sense_n,
    input  logic               sense_s,
    input  logic               sense_e,
    input  logic               sense_w,
    output logic               go_n,
    output logic               go_s,
    output logic               go_e,
    output logic               go_w,
    output logic [PHASE_W-1:0] phase
);

    localparam int unsigned TW        = timer_width(MAX_GREEN);
    localparam int          TIMER_MAX = (2 ** TW) - 1;

    // Parameter sanity: reject configurations that cannot schedule correctly
    if (MIN_GREEN < 1) begin : g_bad_min_green
        $error("MIN_GREEN must be at least 1");
    end
    if (CLEAR < 1) begin : g_bad_clear
        $error("CLEAR must be at least 1");
    end
    if (MAX_GREEN < MIN_GREEN) begin : g_bad_max_green
        $error("MAX_GREEN must not be below MIN_GREEN");
    end
    if (CLEAR - 1 > TIMER_MAX) begin : g_bad_clear_range
        $error("CLEAR exceeds the phase timer range");
    end

    state_e     state_q;
    state_e     state_d;
    group_e     last_q;
    logic [3:0] req_q;      // {n, s, e, w}
    logic [3:0] sense_v;
    logic [3:0] go_v;
    logic       ns_req;
    logic       ew_req;
    logic       timer_clear;
    logic       min_done;
    logic       max_done;
    logic       clear_done;

    assign sense_v = {sense_n, sense_s, sense_e, sense_w};
    assign go_v    = {go_n, go_s, go_e, go_w};
    assign ns_req  = req_q[3] | req_q[2];
    assign ew_req  = req_q[1] | req_q[0];

    // Timer restarts on every state change and on reset
    assign timer_clear = rst | (state_d != state_q);

    phase_timer #(
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN),
        .CLEAR     (CLEAR)
    ) u_phase_timer (
        .clk        (clk),
        .clear      (timer_clear),
        .min_done   (min_done),
        .max_done   (max_done),
        .clear_done (clear_done)
    );

    // Request latches: set by sense, cleared once served and the approach is empty
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else begin
            req_q <= sense_v | (req_q & ~go_v);
        end
    end

    // Remember which phase was served last, for alternation out of IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GRP_EW;
        end else if (state_d == ST_NS_CLEAR && state_q != ST_NS_CLEAR) begin
            last_q <= GRP_NS;
        end else if (state_d == ST_EW_CLEAR && state_q != ST_EW_CLEAR) begin
            last_q <= GRP_EW;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ns_req && (last_q == GRP_EW || !ew_req)) begin
                    state_d = ST_NS_GREEN;
                end else if (ew_req) begin
                    state_d = ST_EW_GREEN;
                end
            end
            ST_NS_GREEN: begin
                if ((min_done && !ns_req) || (max_done && ew_req)) begin
                    state_d = ST_NS_CLEAR;
                end
            end
            ST_NS_CLEAR: begin
                if (clear_done) begin
                    state_d = ew_req ? ST_EW_GREEN : ST_IDLE;
                end
            end
            ST_EW_GREEN: begin
                if ((min_done && !ew_req) || (max_done && ns_req)) begin
                    state_d = ST_EW_CLEAR;
                end
            end
            ST_EW_CLEAR: begin
                if (clear_done) begin
                    state_d = ns_req ? ST_NS_GREEN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        go_n  = 1'b0;
        go_s  = 1'b0;
        go_e  = 1'b0;
        go_w  = 1'b0;
        phase = PHASE_W'(state_q);
        if (state_q == ST_NS_GREEN) begin
            go_n = 1'b1;
            go_s = 1'b1;
        end
        if (state_q == ST_EW_GREEN) begin
            go_e = 1'b1;
            go_w = 1'b1;
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed-vector and random-stimulus bench for traffic_phase_scheduler.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       rst;
    logic       sense_n;
    logic       sense_s;
    logic       sense_e;
    logic       sense_w;
    logic       go_n;
    logic       go_s;
    logic       go_e;
    logic       go_w;
    logic [2:0] phase;

    int n_checks = 0;
    int n_errors = 0;

    // One vector per cycle: drive {rst, n, s, e, w} and the expected phase
    typedef struct {
        logic [4:0] drv;
        int         ph;
    } vec_t;

    vec_t vq[$];

    localparam int GRANT_LIMIT = 40;
    localparam int RAND_CYCLES = 1500;
    localparam int DRAIN_CYCLES = 80;

    traffic_phase_scheduler #(
        .MIN_GREEN (4),
        .MAX_GREEN (16),
        .CLEAR     (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sense_n (sense_n),
        .sense_s (sense_s),
        .sense_e (sense_e),
        .sense_w (sense_w),
        .go_n    (go_n),
        .go_s    (go_s),
        .go_e    (go_e),
        .go_w    (go_w),
        .phase   (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic add(input logic [4:0] d, input int p, input int n = 1);
        vec_t v;
        v.drv = d;
        v.ph  = p;
        repeat (n) vq.push_back(v);
    endtask

    // Apply one reset edge, then confirm the idle, all-red state
    task automatic do_reset();
        rst = 1'b1;
        {sense_n, sense_s, sense_e, sense_w} = 4'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset phase", phase, 0);
        chk("reset go", {go_n, go_s, go_e, go_w}, 0);
        chk("reset latches", dut.req_q, 0);
        @(posedge clk);
        #1;
    endtask

    // Play the queued vectors, checking phase and all four go outputs per cycle
    task automatic run_vec(input string name);
        foreach (vq[i]) begin
            {rst, sense_n, sense_s, sense_e, sense_w} = vq[i].drv;
            @(negedge clk);
            chk($sformatf("%s c%0d phase", name, i), phase, vq[i].ph);
            chk($sformatf("%s c%0d go_n", name, i), go_n, (vq[i].ph == 1) ? 1 : 0);
            chk($sformatf("%s c%0d go_s", name, i), go_s, (vq[i].ph == 1) ? 1 : 0);
            chk($sformatf("%s c%0d go_e", name, i), go_e, (vq[i].ph == 3) ? 1 : 0);
            chk($sformatf("%s c%0d go_w", name, i), go_w, (vq[i].ph == 3) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        {sense_n, sense_s, sense_e, sense_w} = 4'b0;
        vq.delete();
    endtask

    // Random traffic: each approach raises sense, holds it until granted, then releases soon after
    task automatic run_random();
        int   st[4];
        int   cnt[4];
        int   waited[4];
        logic s_v[4];
        logic g_v[4];
        bit   allow_new;
        for (int i = 0; i < 4; i++) begin
            st[i] = 0;
            cnt[i] = 0;
            waited[i] = 0;
        end
        for (int c = 0; c < RAND_CYCLES + DRAIN_CYCLES; c++) begin
            allow_new = (c < RAND_CYCLES);
            for (int i = 0; i < 4; i++) begin
                if (st[i] == 0 && allow_new && $urandom_range(0, 11) == 0) begin
                    st[i] = 1;
                    waited[i] = 0;
                end
                s_v[i] = (st[i] != 0);
            end
            {sense_n, sense_s, sense_e, sense_w} = {s_v[0], s_v[1], s_v[2], s_v[3]};
            @(negedge clk);
            g_v[0] = go_n;
            g_v[1] = go_s;
            g_v[2] = go_e;
            g_v[3] = go_w;
            chk($sformatf("mutex c%0d", c), (go_n | go_s) & (go_e | go_w), 0);
            for (int i = 0; i < 4; i++) begin
                if (st[i] == 1) begin
                    waited[i]++;
                    if (g_v[i] || waited[i] > GRANT_LIMIT) begin
                        chk($sformatf("grant app%0d c%0d", i, c), g_v[i], 1);
                        st[i] = g_v[i] ? 2 : 0;
                        cnt[i] = $urandom_range(0, 5);
                    end
                end else if (st[i] == 2) begin
                    if (cnt[i] == 0) st[i] = 0;
                    else cnt[i]--;
                end
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain app%0d", i), st[i], 0);
        end
        {sense_n, sense_s, sense_e, sense_w} = 4'b0;
    endtask

    initial begin
        rst = 1'b1;
        {sense_n, sense_s, sense_e, sense_w} = 4'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single north pulse: NS green 2-5, clear 6-7, idle from 8
        add(5'b01000, 0);
        add(5'b00000, 0);
        add(5'b00000, 1, 4);
        add(5'b00000, 2, 2);
        add(5'b00000, 0, 2);
        run_vec("single_n");

        // NS served last, so simultaneous n+e requests go EW first
        add(5'b01010, 0);
        add(5'b00000, 0);
        add(5'b00000, 3, 4);
        add(5'b00000, 4, 2);
        add(5'b00000, 1, 4);
        add(5'b00000, 2, 2);
        add(5'b00000, 0, 2);
        run_vec("alternate");

        // After reset last_served is EW, so n+e goes NS first
        do_reset();
        add(5'b01010, 0);
        add(5'b00000, 0);
        add(5'b00000, 1, 4);
        add(5'b00000, 2, 2);
        add(5'b00000, 3, 4);
        add(5'b00000, 4, 2);
        add(5'b00000, 0, 2);
        run_vec("both");

        // East held, south arrives: EW capped at 16 cycles, then NS, then EW again
        do_reset();
        add(5'b00010, 0, 2);
        add(5'b00010, 3);
        add(5'b00110, 3);
        add(5'b00010, 3, 14);
        add(5'b00000, 4, 2);
        add(5'b00000, 1, 4);
        add(5'b00000, 2, 2);
        add(5'b00000, 3, 4);
        add(5'b00000, 4, 2);
        add(5'b00000, 0, 2);
        run_vec("max_green");

        // Reset during NS green with sense still high: immediate idle, nothing latched
        do_reset();
        add(5'b01000, 0, 2);
        add(5'b01000, 1);
        add(5'b11000, 1);
        add(5'b00000, 0, 8);
        run_vec("mid_reset");
        chk("mid_reset latches", dut.req_q, 0);

        do_reset();
        run_random();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 SHALL have parameter MIN_GREEN, default 4: minimum green cycles per phase.
REQ-002 SHALL have parameter MAX_GREEN, default 16: green cycles after which the phase yields to a waiting opposite phase.
REQ-003 SHALL have parameter CLEAR, default 2: all-red clearance cycles between phases.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports sense_n, sense_s, sense_e, sense_w, input, 1 each: car waiting or crossing on that approach.
REQ-007 SHALL have ports go_n, go_s, go_e, go_w, output, 1 each: approach permitted to enter.
REQ-008 SHALL have port phase, output, 3: current state encoding per REQ-012.

Function
REQ-009 SHALL keep one request latch per approach, set on the edge after sense_x=1 is sampled.
REQ-010 SHALL clear latch x on the edge after go_x=1 and sense_x=0 are sampled; set wins over clear.
REQ-011 SHALL group approaches into phase NS (n, s) and phase EW (e, w); ns_req/ew_req = OR of the group's latches.
REQ-012 SHALL implement states IDLE=0, NS_GREEN=1, NS_CLEAR=2, EW_GREEN=3, EW_CLEAR=4.
REQ-013 SHALL keep a last_served bit; after reset last_served=EW.
REQ-014 IDLE: next NS_GREEN if ns_req and (last_served=EW or !ew_req); else EW_GREEN if ew_req; else stay.
REQ-015 SHALL zero the phase timer on every state entry and increment it each cycle in the state.
REQ-016 x_GREEN SHALL go to x_CLEAR when timer>=MIN_GREEN-1 and own-phase request is 0.
REQ-017 x_GREEN SHALL go to x_CLEAR when timer>=MAX_GREEN-1 and the opposite-phase request is 1.
REQ-018 SHALL set last_served to x on entering x_CLEAR.
REQ-019 x_CLEAR SHALL last exactly CLEAR cycles.
REQ-020 On leaving x_CLEAR: go to the opposite GREEN if opposite request=1, else IDLE.
REQ-021 SHALL drive go_n=go_s=(state==NS_GREEN) and go_e=go_w=(state==EW_GREEN), decoded from registered state.
REQ-022 SHALL never assert an NS go and an EW go in the same cycle.
REQ-023 Latency: sense sampled in IDLE at cycle t -> go high at cycle t+2.
REQ-024 The timer SHALL saturate and never wrap; width = clog2(MAX_GREEN)+1.
REQ-025 SHALL reject MIN_GREEN<1, CLEAR<1, or MAX_GREEN<MIN_GREEN at elaboration.

Reset
REQ-026 rst=1 SHALL, on the next edge, set state=IDLE, timer=0, all latches=0, last_served=EW.
REQ-027 All go outputs SHALL read 0 and phase 0 in the cycle following the reset edge.
REQ-028 Reset SHALL override any in-progress GREEN or CLEAR without passing through clearance.

Structure
REQ-029 Package traffic_pkg SHALL hold the state enumeration, the phase-group enumeration (NS/EW) and the parameter defaults.
REQ-030 Sub-module phase_timer SHALL implement the restartable saturating counter with a clear input and compare outputs; everything else SHALL be in the top module.

Verification
REQ-031 Reset, 1-cycle sense_n pulse at cycle 0 -> go_n=go_s=1 cycles 2-5, phase=2 cycles 6-7, IDLE cycle 8.
REQ-032 sense_n and sense_e both pulsed at cycle 0 after reset -> NS green cycles 2-5, clear 6-7, go_e cycles 8-11.
REQ-033 sense_e held high from cycle 0, sense_s pulse at cycle 3 -> go_e exactly 16 cycles (2-17), clear 18-19, go_s from cycle 20.
REQ-034 rst asserted for one edge mid-NS_GREEN -> next cycle all go=0, phase=0, latches=0; no grant without a new sense.
REQ-035 Long random sense stimulus -> REQ-022 mutex holds every cycle.
REQ-036 Same long random stimulus with sense_x released within 20 cycles of go_x -> every asserted sense_x is followed by go_x.
